pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline control unit that drives the write-enable and flush inputs of every inter-stage pipeline register (IF/ID, ID/RR, RR/EX, EX/MEM) and the PC write enable. It resolves load-use hazards by injecting bubbles into RR/EX, squashes wrong-path instructions on an EX-stage redirect, and sequences LM/SM multi-register instructions as one micro-op per cycle. Each micro-op supplies a register index and an ordinal to the RR/EX register. It sits beside the datapath and feeds the `*_Write` / `*_FLUSH` pins that the stage registers consume.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- mem_busy  in  1  data memory not ready; freezes the whole pipeline
- ex_redirect  in  1  branch or jump resolved in EX with the target differing from the fetched path
- ex_valid  in  1  EX holds a real instruction (not a bubble)
- ex_memread  in  1  EX instruction is a load
- ex_dest  in  3  destination register of the EX instruction
- rr_valid  in  1  RR holds a real instruction
- rr_ra, rr_rb  in  3 each  source register indices in RR
- rr_uses_ra, rr_uses_rb  in  1 each  RR instruction reads ra / rb
- rr_is_lmsm  in  1  RR instruction is LM or SM
- rr_is_sm  in  1  RR instruction is SM (qualifies rr_is_lmsm)
- rr_lmsm_mask  in  8  LM/SM register mask; bit k selects register k
- pc_write, if_id_write, id_rr_write, rr_ex_write, ex_mem_write  out  1 each  stage register write enables
- if_flush, id_flush, rr_flush  out  1 each  bubble-insert for IF/ID, ID/RR, RR/EX
- lmsm_reg  out  3  register index for the current LM/SM micro-op
- lmsm_ord  out  3  micro-op ordinal (0 = first); EX address offset is 2*lmsm_ord
- lmsm_active  out  1  sequencer in SEQ state
- stall_count  out  16  saturating count of hazard stall cycles

## Operation
- Outputs are combinational from current state and inputs (Mealy), so the stage registers sample them at the same edge.
- FSM states:
  - IDLE
  - SEQ, which holds `mask_q[7:0]` and `ord_q[2:0]`
- Default when no event is active: all write enables 1, all flushes 0.
- Events are evaluated in strict priority order; only the highest active event applies.

1. **mem_busy:**
   - All write enables 0 and all flushes 0.
   - FSM, mask, ord and stall_count hold.
2. **ex_redirect:**
   - All write enables 1; if_flush, id_flush and rr_flush all 1.
   - FSM goes to IDLE; mask_q and ord_q are cleared.
   - ex_mem_write is 1 (the EX instruction itself survives).
3. **Load-use:** fires when ex_valid & ex_memread and ex_dest matches any active source.
   - Active sources: rr_ra if rr_uses_ra; rr_rb if rr_uses_rb. In SEQ with rr_is_sm, lmsm_reg is also an active source.
   - pc_write, if_id_write and id_rr_write are 0; rr_ex_write=1 with rr_flush=1 (bubble).
   - FSM, mask and ord hold. stall_count increments.
4. **LM/SM in IDLE:** applies when rr_valid & rr_is_lmsm.
   - If rr_lmsm_mask==0: rr_flush=1 (instruction becomes a bubble) and no stall.
   - Otherwise: lmsm_reg = index of the lowest set bit of rr_lmsm_mask, and lmsm_ord=0. Let `rem` be the mask with that bit cleared.
   - If rem!=0: pc_write, if_id_write and id_rr_write are 0, and rr_ex_write=1. Next state is SEQ with mask_q=rem and ord_q=1. stall_count increments.
   - If rem==0: no stall and the FSM stays in IDLE.
5. **SEQ:**
   - lmsm_reg = lowest set bit of mask_q; lmsm_ord = ord_q; rr_ex_write=1.
   - That bit is cleared and ord_q increments.
   - If the cleared mask is nonzero: upstream enables are 0, the FSM stays in SEQ, and stall_count increments.
   - If the cleared mask is zero: upstream enables are 1 (this cycle releases RR) and next state is IDLE.

Output values in IDLE and when no LM/SM is active:
- lmsm_reg=0, lmsm_ord=0.
- lmsm_active=1 only in SEQ.

stall_count:
- Increments only on load-use and LM/SM stall cycles.
- Saturates at 16'hFFFF.

## Timing
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; mask_q=0, ord_q=0, stall_count=0.
  - While rst is low: all write enables 0, all flushes 0, lmsm_reg=0, lmsm_ord=0, lmsm_active=0.
- Reset is asserted asynchronously and released at a clock edge. Reset during SEQ abandons the sequence immediately.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM, the hazard clears, and RR issues.
- LM/SM with N set bits occupies RR for N cycles and emits N micro-ops on consecutive cycles (absent other events). The maximum is 8 with ord 0..7; ord_q never wraps within a legal sequence.
- A redirect during SEQ takes precedence: the remaining micro-ops are dropped and RR is flushed in the same cycle.
- mem_busy during SEQ or load-use freezes all state, and the cycle is not counted in stall_count.
- rr_is_lmsm with rr_valid=0 is ignored.

## Test plan
- **Load-use:** EX=load with ex_dest=3; RR has rr_ra=3 and rr_uses_ra=1.
  - Cycle 1: pc_write=0, if_id_write=0, id_rr_write=0, rr_flush=1, stall_count=1.
  - Next cycle: all write enables 1.
- **LM 8'b1010_0100:**
  - Three cycles with lmsm_reg = 2, 5, 7 and lmsm_ord = 0, 1, 2.
  - pc_write is 0 in the first two cycles and 1 in the third; then the FSM is in IDLE and stall_count=2.
- **Redirect during SEQ:** SM 8'hFF with ex_redirect=1 in its 3rd cycle.
  - if_flush, id_flush and rr_flush all 1; lmsm_active=0 on the next cycle.
  - No further micro-ops are emitted.
- **mem_busy held for 4 cycles mid-SEQ:**
  - All enables 0 throughout; lmsm_reg and lmsm_ord are unchanged.
  - The sequence resumes at the same ord; stall_count does not change during the freeze.
- **Edge masks:**
  - Mask 8'h00 with rr_valid=1 gives rr_flush=1 and no stall.
  - Mask 8'h01 gives a single micro-op with lmsm_reg=0 and no stall.
- **Reset:**
  - rst low mid-SEQ: outputs go to zero immediately (asynchronously); after release the FSM is IDLE with stall_count=0.
  - Force 65540 load-use cycles: stall_count is 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Drives the write enables and flushes of the IF/ID, ID/RR, RR/EX and EX/MEM
// pipeline registers plus the PC write enable. It handles four jobs:
//   - memory-busy freezes of the whole pipeline
//   - squashing the wrong path on an EX redirect
//   - load-use bubbles
//   - sequencing LM/SM into one micro-op per cycle
// All outputs are Mealy so the stage registers act on them at the same edge.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_busy,
    input  logic        ex_redirect,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic [2:0]  ex_dest,
    input  logic        rr_valid,
    input  logic [2:0]  rr_ra,
    input  logic [2:0]  rr_rb,
    input  logic        rr_uses_ra,
    input  logic        rr_uses_rb,
    input  logic        rr_is_lmsm,
    input  logic        rr_is_sm,
    input  logic [7:0]  rr_lmsm_mask,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_rr_write,
    output logic        rr_ex_write,
    output logic        ex_mem_write,
    output logic        if_flush,
    output logic        id_flush,
    output logic        rr_flush,
    output logic [2:0]  lmsm_reg,
    output logic [2:0]  lmsm_ord,
    output logic        lmsm_active,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  ord_q, ord_d;
    logic [15:0] stall_q;
    logic        count_stall;

    logic [2:0]  seq_reg;
    logic [7:0]  seq_rem;
    logic [2:0]  idle_reg;
    logic [7:0]  idle_rem;
    logic        hazard;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

    // Lowest-bit picks for the pending SEQ mask and a new LM/SM in RR,
    // plus the load-use check against every register RR actually reads.
    always_comb begin
        seq_reg  = lowest_bit(mask_q);
        seq_rem  = mask_q & (mask_q - 8'd1);
        idle_reg = lowest_bit(rr_lmsm_mask);
        idle_rem = rr_lmsm_mask & (rr_lmsm_mask - 8'd1);
        hazard   = ex_valid & ex_memread &
                   ((rr_uses_ra & (rr_ra == ex_dest)) |
                    (rr_uses_rb & (rr_rb == ex_dest)) |
                    ((state_q == SEQ) & rr_is_sm & (seq_reg == ex_dest)));
    end

    // Next state and enables, with events resolved in strict priority order:
    // reset, mem_busy, redirect, load-use, then LM/SM handling.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        ord_d        = ord_q;
        count_stall  = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_rr_write  = 1'b1;
        rr_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        rr_flush     = 1'b0;
        lmsm_reg     = 3'd0;
        lmsm_ord     = 3'd0;
        lmsm_active  = 1'b0;

        if (state_q == SEQ) begin
            lmsm_reg    = seq_reg;
            lmsm_ord    = ord_q;
            lmsm_active = 1'b1;
        end

        if (!rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_rr_write  = 1'b0;
            rr_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            lmsm_reg     = 3'd0;
            lmsm_ord     = 3'd0;
            lmsm_active  = 1'b0;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_rr_write  = 1'b0;
            rr_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (ex_redirect) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            rr_flush = 1'b1;
            state_d  = IDLE;
            mask_d   = 8'd0;
            ord_d    = 3'd0;
        end else if (hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_rr_write = 1'b0;
            rr_flush    = 1'b1;
            count_stall = 1'b1;
        end else if (state_q == IDLE) begin
            if (rr_valid && rr_is_lmsm) begin
                if (rr_lmsm_mask == 8'd0) begin
                    rr_flush = 1'b1;
                end else begin
                    lmsm_reg = idle_reg;
                    lmsm_ord = 3'd0;
                    if (idle_rem != 8'd0) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_rr_write = 1'b0;
                        state_d     = SEQ;
                        mask_d      = idle_rem;
                        ord_d       = 3'd1;
                        count_stall = 1'b1;
                    end
                end
            end
        end else begin
            mask_d = seq_rem;
            ord_d  = ord_q + 3'd1;
            if (seq_rem != 8'd0) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_rr_write = 1'b0;
                count_stall = 1'b1;
            end else begin
                state_d = IDLE;
                ord_d   = 3'd0;
            end
        end
    end

    // Sequencer state and the saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mask_q  <= 8'd0;
            ord_q   <= 3'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ord_q   <= ord_d;
            if (count_stall && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Table-driven bench for pipeline_hazard_ctrl. Each vector is one clock cycle.
// Inputs are driven on the falling edge and outputs are checked before the
// next rising edge. Hand-written sequences cover async reset and saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_busy;
    logic        ex_redirect;
    logic        ex_valid;
    logic        ex_memread;
    logic [2:0]  ex_dest;
    logic        rr_valid;
    logic [2:0]  rr_ra;
    logic [2:0]  rr_rb;
    logic        rr_uses_ra;
    logic        rr_uses_rb;
    logic        rr_is_lmsm;
    logic        rr_is_sm;
    logic [7:0]  rr_lmsm_mask;
    logic        pc_write;
    logic        if_id_write;
    logic        id_rr_write;
    logic        rr_ex_write;
    logic        ex_mem_write;
    logic        if_flush;
    logic        id_flush;
    logic        rr_flush;
    logic [2:0]  lmsm_reg;
    logic [2:0]  lmsm_ord;
    logic        lmsm_active;
    logic [15:0] stall_count;

    typedef struct {
        string       name;
        logic [25:0] in;
        logic [30:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   vec_count;
    int   miss_count;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam logic [4:0] W_ALL   = 5'b11111;
    localparam logic [4:0] W_STALL = 5'b00011;
    localparam logic [4:0] W_NONE  = 5'b00000;
    localparam logic [2:0] F_NONE  = 3'b000;
    localparam logic [2:0] F_RR    = 3'b001;
    localparam logic [2:0] F_ALL   = 3'b111;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_busy     (mem_busy),
        .ex_redirect  (ex_redirect),
        .ex_valid     (ex_valid),
        .ex_memread   (ex_memread),
        .ex_dest      (ex_dest),
        .rr_valid     (rr_valid),
        .rr_ra        (rr_ra),
        .rr_rb        (rr_rb),
        .rr_uses_ra   (rr_uses_ra),
        .rr_uses_rb   (rr_uses_rb),
        .rr_is_lmsm   (rr_is_lmsm),
        .rr_is_sm     (rr_is_sm),
        .rr_lmsm_mask (rr_lmsm_mask),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_rr_write  (id_rr_write),
        .rr_ex_write  (rr_ex_write),
        .ex_mem_write (ex_mem_write),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .rr_flush     (rr_flush),
        .lmsm_reg     (lmsm_reg),
        .lmsm_ord     (lmsm_ord),
        .lmsm_active  (lmsm_active),
        .stall_count  (stall_count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [25:0] mkIn(
        input logic busy, input logic redir, input logic exv, input logic exmr,
        input logic [2:0] exd, input logic rrv, input logic [2:0] ra,
        input logic [2:0] rb, input logic ura, input logic urb,
        input logic lm, input logic sm, input logic [7:0] mask);
        return {busy, redir, exv, exmr, exd, rrv, ra, rb, ura, urb, lm, sm, mask};
    endfunction

    function automatic logic [30:0] mkOut(
        input logic [4:0] w, input logic [2:0] f, input logic [2:0] r,
        input logic [2:0] o, input logic a, input logic [15:0] s);
        return {w, f, r, o, a, s};
    endfunction

    task automatic addVec(input string name, input logic [25:0] in, input logic [30:0] exp);
        vec_t v;
        v.name = name;
        v.in   = in;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic driveInputs(input logic [25:0] in);
        {mem_busy, ex_redirect, ex_valid, ex_memread, ex_dest, rr_valid, rr_ra, rr_rb,
         rr_uses_ra, rr_uses_rb, rr_is_lmsm, rr_is_sm, rr_lmsm_mask} = in;
    endtask

    task automatic checkOutput(input string name, input logic [30:0] exp);
        logic [30:0] act;
        act = {pc_write, if_id_write, id_rr_write, rr_ex_write, ex_mem_write,
               if_flush, id_flush, rr_flush, lmsm_reg, lmsm_ord, lmsm_active, stall_count};
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got wr=%b fl=%b reg=%0d ord=%0d act=%b stall=%h, want wr=%b fl=%b reg=%0d ord=%0d act=%b stall=%h",
                     name, act[30:26], act[25:23], act[22:20], act[19:17], act[16], act[15:0],
                     exp[30:26], exp[25:23], exp[22:20], exp[19:17], exp[16], exp[15:0]);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveInputs(v.in);
        #2;
        checkOutput(v.name, v.exp);
    endtask

    // Vector table, then the reset and saturation sequences.
    initial begin
        logic [25:0] idle_in;
        logic [25:0] lu_in;
        logic [25:0] sm_ff;

        vec_count  = 0;
        miss_count = 0;
        idle_in = mkIn(N,N,N,N,3'd0,Y,3'd1,3'd2,Y,Y,N,N,8'h00);
        lu_in   = mkIn(N,N,Y,Y,3'd3,Y,3'd3,3'd0,Y,N,N,N,8'h00);
        sm_ff   = mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,Y,8'hFF);

        addVec("idle",         idle_in,                                     mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd0));
        addVec("loaduse_ra",   lu_in,                                       mkOut(W_STALL,F_RR,  3'd0,3'd0,N,16'd0));
        addVec("after_lu",     mkIn(N,N,N,N,3'd0,Y,3'd3,3'd0,Y,N,N,N,8'h00),mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd1));
        addVec("lu_ra_unused", mkIn(N,N,Y,Y,3'd5,Y,3'd5,3'd2,N,Y,N,N,8'h00),mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd1));
        addVec("lu_rb",        mkIn(N,N,Y,Y,3'd5,Y,3'd1,3'd5,Y,Y,N,N,8'h00),mkOut(W_STALL,F_RR,  3'd0,3'd0,N,16'd1));
        addVec("lu_notload",   mkIn(N,N,Y,N,3'd5,Y,3'd1,3'd5,Y,Y,N,N,8'h00),mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd2));
        addVec("lu_exinvalid", mkIn(N,N,N,Y,3'd5,Y,3'd1,3'd5,Y,Y,N,N,8'h00),mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd2));
        addVec("lm_a",         mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'hA4),mkOut(W_STALL,F_NONE,3'd2,3'd0,N,16'd2));
        addVec("lm_b",         mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'hA4),mkOut(W_STALL,F_NONE,3'd5,3'd1,Y,16'd3));
        addVec("lm_c",         mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'hA4),mkOut(W_ALL,  F_NONE,3'd7,3'd2,Y,16'd4));
        addVec("after_lm",     idle_in,                                     mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd4));
        addVec("mask00",       mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'h00),mkOut(W_ALL,  F_RR,  3'd0,3'd0,N,16'd4));
        addVec("mask01",       mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'h01),mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd4));
        addVec("mask80",       mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'h80),mkOut(W_ALL,  F_NONE,3'd7,3'd0,N,16'd4));
        addVec("lm_invalid",   mkIn(N,N,N,N,3'd0,N,3'd0,3'd0,N,N,Y,N,8'hFF),mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd4));
        addVec("sm_1",         sm_ff,                                       mkOut(W_STALL,F_NONE,3'd0,3'd0,N,16'd4));
        addVec("sm_2",         sm_ff,                                       mkOut(W_STALL,F_NONE,3'd1,3'd1,Y,16'd5));
        addVec("sm_redir",     mkIn(N,Y,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,Y,8'hFF),mkOut(W_ALL,  F_ALL, 3'd2,3'd2,Y,16'd6));
        addVec("after_redir",  idle_in,                                     mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd6));
        addVec("lmb_1",        mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'h0F),mkOut(W_STALL,F_NONE,3'd0,3'd0,N,16'd6));
        for (int i = 0; i < 4; i++) begin
            addVec("lmb_busy", mkIn(Y,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'h0F),mkOut(W_NONE, F_NONE,3'd1,3'd1,Y,16'd7));
        end
        addVec("lmb_2",        mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'h0F),mkOut(W_STALL,F_NONE,3'd1,3'd1,Y,16'd7));
        addVec("lmb_3",        mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,N,8'h0F),mkOut(W_STALL,F_NONE,3'd2,3'd2,Y,16'd8));
        addVec("lmb_lu_lm",    mkIn(N,N,Y,Y,3'd3,Y,3'd0,3'd0,N,N,Y,N,8'h0F),mkOut(W_ALL,  F_NONE,3'd3,3'd3,Y,16'd9));
        addVec("sml_1",        mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,Y,8'h18),mkOut(W_STALL,F_NONE,3'd3,3'd0,N,16'd9));
        addVec("sml_lu",       mkIn(N,N,Y,Y,3'd4,Y,3'd0,3'd0,N,N,Y,Y,8'h18),mkOut(W_STALL,F_RR,  3'd4,3'd1,Y,16'd10));
        addVec("sml_lu_busy",  mkIn(Y,N,Y,Y,3'd4,Y,3'd0,3'd0,N,N,Y,Y,8'h18),mkOut(W_NONE, F_NONE,3'd4,3'd1,Y,16'd11));
        addVec("sml_2",        mkIn(N,N,N,N,3'd0,Y,3'd0,3'd0,N,N,Y,Y,8'h18),mkOut(W_ALL,  F_NONE,3'd4,3'd1,Y,16'd11));
        addVec("idle_end",     idle_in,                                     mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd11));
        addVec("busy_redir",   mkIn(Y,Y,N,N,3'd0,Y,3'd1,3'd2,Y,Y,N,N,8'h00),mkOut(W_NONE, F_NONE,3'd0,3'd0,N,16'd11));
        addVec("redir_lu",     mkIn(N,Y,Y,Y,3'd3,Y,3'd3,3'd0,Y,N,N,N,8'h00),mkOut(W_ALL,  F_ALL, 3'd0,3'd0,N,16'd11));
        addVec("idle_chk",     idle_in,                                     mkOut(W_ALL,  F_NONE,3'd0,3'd0,N,16'd11));

        rst = 1'b0;
        driveInputs(idle_in);
        #3;
        checkOutput("reset_initial", mkOut(W_NONE,F_NONE,3'd0,3'd0,N,16'd0));
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Async reset in the middle of an SM sequence.
        @(negedge clk);
        driveInputs(sm_ff);
        @(negedge clk);
        #1;
        checkOutput("seq_before_reset", mkOut(W_STALL,F_NONE,3'd1,3'd1,Y,16'd12));
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_async", mkOut(W_NONE,F_NONE,3'd0,3'd0,N,16'd0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", mkOut(W_NONE,F_NONE,3'd0,3'd0,N,16'd0));
        @(negedge clk);
        rst = 1'b1;
        driveInputs(idle_in);
        #2;
        checkOutput("reset_release", mkOut(W_ALL,F_NONE,3'd0,3'd0,N,16'd0));

        // Hold a load-use hazard long enough to saturate the counter.
        @(negedge clk);
        driveInputs(lu_in);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        #2;
        checkOutput("stall_sat", mkOut(W_STALL,F_RR,3'd0,3'd0,N,16'hFFFF));
        @(negedge clk);
        #2;
        checkOutput("stall_sat_hold", mkOut(W_STALL,F_RR,3'd0,3'd0,N,16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
